riscv_sequencer: RTL and testbench
==================================

# riscv_sequencer

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared register file, ALU and single memory port. It consumes `opcode` from the instruction decoder and `branch_taken` from the comparator, and drives every datapath enable and mux select, the memory request handshake, and a retired-instruction counter.

## Interface
- `INSTRET_WIDTH`, 32, width of the retired-instruction counter.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  start/continue; sampled only in IDLE.
- `opcode`  in  7  decoder opcode field of the current IR.
- `branch_taken`  in  1  comparator result, valid in EXECUTE.
- `mem_ack`  in  1  memory completes the pending transfer.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  request is a store.
- `mem_addr_sel`  out  1  address source: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  load IR from memory read data.
- `pc_we`  out  1  update PC.
- `pc_src`  out  2  next-PC source: 0 = PC+4, 1 = PC+offset (JAL/branch), 2 = (rs1+offset)&~1 (JALR).
- `alu_a_sel`  out  1  ALU operand A: 0 = rs1, 1 = PC.
- `alu_b_sel`  out  2  ALU operand B: 0 = rs2, 1 = imm12, 2 = store_offset, 3 = imm20.
- `reg_we`  out  1  register-file write.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4, 3 = imm20.
- `halted`  out  1  SYSTEM instruction retired; core stopped.
- `trap`  out  1  illegal opcode seen (only with `RISCV_TRAP_EN`).
- `instret`  out  INSTRET_WIDTH  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP.
- IDLE → FETCH when `run`=1; otherwise remain in IDLE.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr_sel`=0. On `mem_ack`: `ir_we`=1, go to DECODE.
- DECODE: exactly one cycle for register-file read → EXECUTE. Exception: SYSTEM (0x73) → HALT.
- EXECUTE, per opcode:
  - OP (0x33): A=rs1, B=rs2 → WRITEBACK.
  - OP_IMM (0x13): B=imm12 → WRITEBACK.
  - LOAD (0x03): B=imm12 → MEM.
  - STORE (0x23): B=store_offset → MEM.
  - LUI (0x37): → WRITEBACK.
  - AUIPC (0x17): A=PC, B=imm20 → WRITEBACK.
  - JAL (0x6F), JALR (0x67): → WRITEBACK.
  - BRANCH (0x63): `pc_we`=1, `pc_src`=1 if `branch_taken` else 0; retire → FETCH.
  - MISC_MEM (0x0F): `pc_we`=1, `pc_src`=0; retire → FETCH.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE. On ack: LOAD → WRITEBACK; STORE asserts `pc_we`, `pc_src`=0, retires → FETCH.
- WRITEBACK: `reg_we`=1 with `wb_sel` = 0 (OP/OP_IMM/AUIPC), 1 (LOAD), 3 (LUI), 2 (JAL/JALR). `pc_we`=1 with `pc_src` = 1 (JAL), 2 (JALR), else 0. Retire → FETCH.
- Retire: `instret` += 1, wrapping modulo 2^INSTRET_WIDTH. A SYSTEM entry into HALT also retires.
- HALT: `halted`=1, all enables 0. Left only by reset.
- All enables and selects not listed for a state are 0.

## Timing
- Reset (asynchronous): state = IDLE, `instret`=0, all outputs 0.
- `mem_req`, `mem_we` and `mem_addr_sel` are held stable until the cycle `mem_ack` is sampled high. Ack may arrive in the first request cycle (zero wait). `mem_ack` while `mem_req`=0 is ignored.
- Cycles per instruction with zero-wait memory:
  - OP / OP_IMM / LUI / AUIPC / JAL / JALR: 4.
  - LOAD: 5.
  - STORE, BRANCH, MISC_MEM: 3 for BRANCH and MISC_MEM; 4 for STORE.
  - Each memory wait cycle adds 1.
- Reset asserted mid-transfer drops `mem_req` immediately, asynchronously. No partial instruction retires.
- `run` deasserted after leaving IDLE has no effect. The sequencer returns to IDLE only through reset.

## Configuration
- `RISCV_TRAP_EN` defined:
  - An unrecognised opcode in DECODE → TRAP.
  - TRAP: `trap`=1, no writes, no retire; exit only by reset.
- `RISCV_TRAP_EN` undefined:
  - An unrecognised opcode executes as MISC_MEM (PC+4, retire).
  - `trap` is tied to 0.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants;
  - the state enum;
  - `pc_src`, `alu_b_sel` and `wb_sel` encodings;
  - the existing `ALU_OP_*` defines.
- Sub-module `riscv_opcode_class`: combinational opcode → class one-hot (alu, imm, load, store, branch, jal, jalr, lui, auipc, fence, system, illegal). It feeds the FSM next-state logic.

## Test plan
- ADDI (0x00500093), zero-wait memory → FETCH/DECODE/EXECUTE/WRITEBACK. `reg_we`=1 with `wb_sel`=0, `alu_b_sel`=1; `pc_src`=0; `instret` 0→1 in cycle 4.
- LW with `mem_ack` delayed 3 cycles in MEM → `mem_req`, `mem_addr_sel`=1 held for 4 cycles, then WRITEBACK `wb_sel`=1; total 8 cycles.
- BEQ with `branch_taken`=1, then =0 → `pc_we` with `pc_src`=1, then 0; 3 cycles each; no `reg_we`.
- JALR → WRITEBACK asserts `reg_we`, `wb_sel`=2, `pc_src`=2. ECALL (0x73) → `halted`=1; later `run` toggles and `mem_ack` pulses cause no change.
- Opcode 0x7F: with `RISCV_TRAP_EN`, `trap`=1 and `instret` unchanged; without it, PC+4 and `instret` increments.
- `reset_n` low during FETCH wait → `mem_req`=0 immediately, state IDLE, `instret`=0; with `INSTRET_WIDTH`=4, 16 retirements wrap `instret` to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, sequencer state, datapath select encodings and opcode class.
package riscv_pkg;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_SLL  = 4'd5;
  localparam logic [3:0] ALU_OP_SRL  = 4'd6;
  localparam logic [3:0] ALU_OP_SRA  = 4'd7;
  localparam logic [3:0] ALU_OP_SLT  = 4'd8;
  localparam logic [3:0] ALU_OP_SLTU = 4'd9;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_TRAP
  } state_t;
  typedef enum logic [1:0] {PC_PLUS4, PC_OFFSET, PC_JALR} pc_src_t;
  typedef enum logic [1:0] {B_RS2, B_IMM12, B_STORE, B_IMM20} alu_b_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM20} wb_sel_t;
  typedef struct packed {
    logic alu, imm, load, store, branch, jal, jalr, lui, auipc, fence, system, illegal;
  } opc_class_t;
endpackage

// File: rtl/riscv_opcode_class.sv
// riscv_opcode_class: combinational opcode to one-hot instruction class.
module riscv_opcode_class
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output opc_class_t cls
);
  assign cls.alu     = opcode == OPC_OP;
  assign cls.imm     = opcode == OPC_OP_IMM;
  assign cls.load    = opcode == OPC_LOAD;
  assign cls.store   = opcode == OPC_STORE;
  assign cls.branch  = opcode == OPC_BRANCH;
  assign cls.jal     = opcode == OPC_JAL;
  assign cls.jalr    = opcode == OPC_JALR;
  assign cls.lui     = opcode == OPC_LUI;
  assign cls.auipc   = opcode == OPC_AUIPC;
  assign cls.fence   = opcode == OPC_MISC_MEM;
  assign cls.system  = opcode == OPC_SYSTEM;
  assign cls.illegal = !(opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                         OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM});
endmodule

// File: rtl/riscv_sequencer.sv
// riscv_sequencer: multi-cycle RV32I control FSM; define RISCV_TRAP_EN to trap on illegal opcodes.
module riscv_sequencer
  import riscv_pkg::*;
#(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic [6:0]               opcode,
  input  logic                     branch_taken,
  input  logic                     mem_ack,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_addr_sel,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic [1:0]               pc_src,
  output logic                     alu_a_sel,
  output logic [1:0]               alu_b_sel,
  output logic                     reg_we,
  output logic [1:0]               wb_sel,
  output logic                     halted,
  output logic                     trap,
  output logic [INSTRET_WIDTH-1:0] instret
);
  state_t state, state_nx;
  opc_class_t cls;
  logic retire, trap_op, fence_like;
  riscv_opcode_class u_cls (.opcode(opcode), .cls(cls));
`ifdef RISCV_TRAP_EN
  assign trap_op    = cls.illegal;
  assign fence_like = cls.fence;
  assign trap       = state == S_TRAP;
`else
  assign trap_op    = 1'b0;
  assign fence_like = cls.fence | cls.illegal;
  assign trap       = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) instret <= '0;
    else if (retire) instret <= instret + INSTRET_WIDTH'(1);
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = run ? S_FETCH : S_IDLE;
      S_FETCH:     state_nx = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE:    state_nx = cls.system ? S_HALT : trap_op ? S_TRAP : S_EXECUTE;
      S_EXECUTE:   state_nx = (cls.branch | fence_like) ? S_FETCH :
                              (cls.load | cls.store) ? S_MEM : S_WRITEBACK;
      S_MEM:       state_nx = !mem_ack ? S_MEM : cls.store ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_nx = S_FETCH;
      default:     state_nx = state;
    endcase
  end
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = B_RS2;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    halted       = 1'b0;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      S_DECODE: retire = cls.system;
      S_EXECUTE: begin
        alu_a_sel = cls.auipc;
        alu_b_sel = cls.alu ? B_RS2 : cls.auipc ? B_IMM20 : cls.store ? B_STORE :
                    (cls.imm | cls.load) ? B_IMM12 : B_RS2;
        pc_we     = cls.branch | fence_like;
        pc_src    = (cls.branch & branch_taken) ? PC_OFFSET : PC_PLUS4;
        retire    = cls.branch | fence_like;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls.store;
        pc_we        = cls.store & mem_ack;
        retire       = cls.store & mem_ack;
      end
      S_WRITEBACK: begin
        reg_we = 1'b1;
        wb_sel = cls.load ? WB_MEM : cls.lui ? WB_IMM20 : (cls.jal | cls.jalr) ? WB_PC4 : WB_ALU;
        pc_we  = 1'b1;
        pc_src = cls.jal ? PC_OFFSET : cls.jalr ? PC_JALR : PC_PLUS4;
        retire = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_riscv_sequencer.sv
// tb_riscv_sequencer: directed checks of the sequencer with a 4-bit retired-instruction counter.
module tb_riscv_sequencer;
  logic clock = 0, reset_n = 0, run = 0, branch_taken = 0, mem_ack = 0;
  logic [6:0] opcode = 7'h00;
  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_a_sel, reg_we, halted, trap;
  logic [1:0] pc_src, alu_b_sel, wb_sel;
  logic [3:0] instret;
  logic [15:0] ctl_obs;
  int n_cmp = 0, n_bad = 0;

  riscv_sequencer #(.INSTRET_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .halted(halted), .trap(trap), .instret(instret)
  );

  always #5 clock = ~clock;

  assign ctl_obs = {1'b0, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_a_sel,
                    alu_b_sel, reg_we, wb_sel, halted, trap};

  function automatic logic [15:0] ctl(bit rq, bit we, bit as, bit ir, bit pw, logic [1:0] ps,
                                      bit aa, logic [1:0] bs, bit rw, logic [1:0] ws, bit h, bit t);
    return {1'b0, rq, we, as, ir, pw, ps, aa, bs, rw, ws, h, t};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic see(string tag, logic [15:0] exp);
    #1;
    chk(tag, ctl_obs, exp);
  endtask

  // Starts in FETCH, ends at the first cycle after DECODE.
  task automatic fetch(logic [6:0] op, int waits);
    opcode = op;
    mem_ack = 0;
    repeat (waits) begin
      see("fetch_wait", ctl(1,0,0,0,0,0,0,0,0,0,0,0));
      step();
    end
    mem_ack = 1;
    see("fetch_ack", ctl(1,0,0,1,0,0,0,0,0,0,0,0));
    step();
    mem_ack = 0;
    see("decode", 16'h0);
    step();
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ctl", ctl_obs, 16'h0);
    chk("reset_instret", instret, 0);
    reset_n = 1;
    step();
    see("idle_hold", 16'h0);
    run = 1;
    step();
    run = 0;
    fetch(7'h13, 0);
    see("addi_ex", ctl(0,0,0,0,0,0,0,1,0,0,0,0));
    step();
    see("addi_wb", ctl(0,0,0,0,1,0,0,0,1,0,0,0));
    chk("addi_instret_pre", instret, 0);
    step();
    chk("addi_instret", instret, 1);
    fetch(7'h03, 0);
    see("lw_ex", ctl(0,0,0,0,0,0,0,1,0,0,0,0));
    step();
    repeat (3) begin
      see("lw_mem_wait", ctl(1,0,1,0,0,0,0,0,0,0,0,0));
      step();
    end
    mem_ack = 1;
    see("lw_mem_ack", ctl(1,0,1,0,0,0,0,0,0,0,0,0));
    step();
    mem_ack = 0;
    see("lw_wb", ctl(0,0,0,0,1,0,0,0,1,1,0,0));
    step();
    chk("lw_instret", instret, 2);
    fetch(7'h63, 0);
    branch_taken = 1;
    see("beq_taken", ctl(0,0,0,0,1,1,0,0,0,0,0,0));
    step();
    branch_taken = 0;
    chk("beq_taken_instret", instret, 3);
    fetch(7'h63, 0);
    see("beq_not_taken", ctl(0,0,0,0,1,0,0,0,0,0,0,0));
    step();
    chk("beq_nt_instret", instret, 4);
    fetch(7'h67, 0);
    see("jalr_ex", 16'h0);
    step();
    see("jalr_wb", ctl(0,0,0,0,1,2,0,0,1,2,0,0));
    step();
    chk("jalr_instret", instret, 5);
    fetch(7'h23, 1);
    see("sw_ex", ctl(0,0,0,0,0,0,0,2,0,0,0,0));
    step();
    mem_ack = 1;
    see("sw_mem", ctl(1,1,1,0,1,0,0,0,0,0,0,0));
    step();
    mem_ack = 0;
    chk("sw_instret", instret, 6);
    fetch(7'h17, 0);
    see("auipc_ex", ctl(0,0,0,0,0,0,1,3,0,0,0,0));
    step();
    see("auipc_wb", ctl(0,0,0,0,1,0,0,0,1,0,0,0));
    step();
    fetch(7'h37, 0);
    see("lui_ex", 16'h0);
    step();
    see("lui_wb", ctl(0,0,0,0,1,0,0,0,1,3,0,0));
    step();
    chk("lui_instret", instret, 8);
    fetch(7'h73, 0);
    see("halt", ctl(0,0,0,0,0,0,0,0,0,0,1,0));
    chk("ecall_instret", instret, 9);
    repeat (4) begin
      run = ~run;
      mem_ack = ~mem_ack;
      step();
      see("halt_hold", ctl(0,0,0,0,0,0,0,0,0,0,1,0));
    end
    run = 0;
    mem_ack = 0;
    chk("halt_instret", instret, 9);
    reset_n = 0;
    step();
    reset_n = 1;
    run = 1;
    step();
    run = 0;
    fetch(7'h13, 0);
    step();
    step();
    chk("pre_rst_instret", instret, 1);
    see("rst_fetch_wait", ctl(1,0,0,0,0,0,0,0,0,0,0,0));
    #2;
    reset_n = 0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_instret", instret, 0);
    step();
    chk("rst_idle_ctl", ctl_obs, 16'h0);
    reset_n = 1;
    run = 1;
    step();
    run = 0;
    fetch(7'h7f, 0);
`ifdef RISCV_TRAP_EN
    see("trap", ctl(0,0,0,0,0,0,0,0,0,0,0,1));
    step();
    see("trap_hold", ctl(0,0,0,0,0,0,0,0,0,0,0,1));
    chk("trap_instret", instret, 0);
`else
    see("illegal_ex", ctl(0,0,0,0,1,0,0,0,0,0,0,0));
    step();
    chk("illegal_instret", instret, 1);
`endif
    reset_n = 0;
    step();
    reset_n = 1;
    run = 1;
    step();
    run = 0;
    for (int i = 0; i < 16; i++) begin
      opcode = 7'h13;
      mem_ack = 1;
      step();
      mem_ack = 0;
      step();
      step();
      step();
      if (i == 14) chk("wrap_15", instret, 15);
    end
    chk("wrap_0", instret, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
